// File: rtl/prog_mem_loader.sv
// Program memory for the 4-bit CPU: 16 x 8 instruction store with a byte-stream
// loader that holds the CPU in reset while a new program is written.
module prog_mem_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  input  logic       load_end,
  input  logic [3:0] cpu_addr,
  output logic [7:0] cpu_data,
  output logic       cpu_n_reset,
  output logic       busy,
  output logic [4:0] load_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_FILL,
    ST_RELEASE
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] wr_ptr_reg, wr_ptr_next;
  logic [4:0] rx_cnt_reg, rx_cnt_next;
  logic [4:0] load_count_reg;
  logic       cpu_n_reset_reg;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_reg [16];

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    rx_cnt_next = rx_cnt_reg;
    mem_we      = 1'b0;
    mem_wdata   = 8'h00;
    case (state_reg)
      ST_RUN: begin
        if (load_start) begin
          state_next  = ST_LOAD;
          wr_ptr_next = 4'd0;
          rx_cnt_next = 5'd0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          mem_we      = 1'b1;
          mem_wdata   = load_data;
          wr_ptr_next = wr_ptr_reg + 4'd1;
          rx_cnt_next = rx_cnt_reg + 5'd1;
        end
        // A transfer into the last slot completes the program even if load_end
        // arrives with it; otherwise load_end pads the remainder with zeros.
        if (load_valid && (wr_ptr_reg == 4'd15)) begin
          state_next = ST_RELEASE;
        end else if (load_end) begin
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_we      = 1'b1;
        mem_wdata   = 8'h00;
        wr_ptr_next = wr_ptr_reg + 4'd1;
        if (wr_ptr_reg == 4'd15) begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      wr_ptr_reg      <= 4'd0;
      rx_cnt_reg      <= 5'd0;
      load_count_reg  <= 5'd0;
      cpu_n_reset_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      rx_cnt_reg      <= rx_cnt_next;
      // Registered from the next state so the CPU still sees reset at the edge ending RELEASE.
      cpu_n_reset_reg <= (state_next == ST_RUN);
      if (state_reg == ST_RELEASE) begin
        load_count_reg <= rx_cnt_reg;
      end
    end
  end

  // Flop-based storage: every word is cleared by reset, which a RAM macro cannot do.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= 8'h00;
        end else if (mem_we && (wr_ptr_reg == 4'(gi))) begin
          mem_reg[gi] <= mem_wdata;
        end
      end
    end
  endgenerate

  assign cpu_data    = mem_reg[cpu_addr];
  assign cpu_n_reset = cpu_n_reset_reg;
  assign busy        = (state_reg != ST_RUN);
  assign load_ready  = (state_reg == ST_LOAD);
  assign load_count  = load_count_reg;

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Program memory for the 4-bit CPU: a 16 × 8-bit array that serves instruction bytes to the CPU fetch port (`addr` → `data`) and can be rewritten at run time from a byte-stream load interface. While a load is in progress the block holds the CPU in reset. It then releases the CPU so execution restarts at address 0 with the new program. It sits directly upstream of the CPU, between the board-level loader source (UART receiver or test bench) and the CPU instruction port.

## Interface
- No parameters. Depth is fixed at 16 and width at 8, matching the 4-bit CPU address and 8-bit instruction.
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `load_start` input 1: single-cycle request to begin a load; sampled only in RUN.
- `load_valid` input 1: `load_data` is valid.
- `load_ready` output 1: block accepts a byte this cycle.
- `load_data` input 8: instruction byte to write.
- `load_end` input 1: terminates the load early; sampled only in LOAD.
- `cpu_addr` input 4: CPU fetch address (CPU `addr`).
- `cpu_data` output 8: instruction byte to CPU (CPU `data`).
- `cpu_n_reset` output 1: active-low reset driven into the CPU.
- `busy` output 1: high whenever the state is not RUN.
- `load_count` output 5: number of bytes received in the last completed load, 0..16.

## Operation
- Storage: `mem[0..15]`, 8 bits each. `cpu_data = mem[cpu_addr]` is combinational in every state.
- FSM states: RUN, LOAD, FILL, RELEASE.
- RUN:
  - `load_ready`=0.
  - If `load_start`=1, go to LOAD; set `wr_ptr`=0 and `rx_cnt`=0.
- LOAD:
  - `load_ready`=1.
  - A transfer occurs when `load_valid && load_ready`. It writes `mem[wr_ptr]`=`load_data` and increments both `wr_ptr` and `rx_cnt`.
  - On a transfer with `wr_ptr`==15, go to RELEASE (16 bytes received).
  - If `load_end`=1, any transfer in the same cycle is applied first. Then go to FILL if fewer than 16 bytes have been written in total, else go to RELEASE.
  - `load_start` is ignored.
- FILL:
  - `load_ready`=0.
  - Each cycle, write `mem[wr_ptr]`=8'h00 and increment `wr_ptr`.
  - After writing address 15, go to RELEASE. Stale bytes from an older program never survive a short load.
- RELEASE:
  - One cycle.
  - Latch `load_count`=`rx_cnt`.
  - Go to RUN.
- `cpu_n_reset` is registered: `cpu_n_reset <= (next_state == RUN) && !reset`.
- `busy` = (state != RUN), combinational from the state register.
- `wr_ptr` is 4 bits. `rx_cnt` is 5 bits, so that the value 16 is representable. `wr_ptr` wraps only implicitly: it is never used after the write to address 15.

## Timing
- Reset (synchronous, while `reset`=1 at an edge):
  - state=RUN, all `mem`=8'h00, `wr_ptr`=0, `rx_cnt`=0, `load_count`=0.
  - `cpu_n_reset`=0, `busy`=0, `load_ready`=0.
  - `cpu_data`=8'h00 for any address.
- First edge with `reset`=0 and state RUN: `cpu_n_reset` becomes 1.
- `load_start` sampled at edge k:
  - From k+1, state=LOAD, `busy`=1, `load_ready`=1, `cpu_n_reset`=0.
- Full load:
  - Minimum 16 cycles in LOAD, one byte per cycle with `load_valid` held high.
  - Then 1 cycle in RELEASE.
  - `cpu_n_reset` returns to 1 at the edge that ends RELEASE.
  - Guaranteed: the CPU sees `n_reset`=0 at one or more rising edges, including the edge that ends RELEASE. Its first unreset fetch therefore reads `mem[0]` of the new program.
- Early end after N bytes: N LOAD transfer cycles, then (16−N) FILL cycles, then 1 RELEASE cycle.
- `load_end` with N=0: 16 FILL cycles; memory ends all zero; `load_count`=0.
- `load_valid` low in LOAD: no write, no pointer change, state held indefinitely (no timeout).
- `reset` asserted mid-load or mid-fill: takes effect at that edge. Memory is cleared and the partial program is discarded.
- `load_count` updates only at RELEASE. It holds its previous value throughout LOAD and FILL.

## Test plan
- Reset, then release → `cpu_n_reset` 0 during reset, 1 one edge later; `cpu_data`=8'h00 for all 16 `cpu_addr`; `busy`=0.
- `load_start`, then 16 back-to-back bytes 8'h30..8'h3F → `load_ready`=1 for exactly 16 cycles, then RELEASE; `mem[i]`=8'h30+i; `load_count`=16; `cpu_n_reset` low from cycle after start until the end of RELEASE.
- Preload all 8'hFF; load 3 bytes (8'h31, 8'h01, 8'hF1) with `load_end` on the third transfer → 13 FILL cycles; `mem[0..2]` as sent, `mem[3..15]`=8'h00; `load_count`=3.
- `load_valid` toggling 1/0 every cycle over 4 bytes, then `load_end` alone → only valid cycles write; bytes land at addresses 0..3 in order; `load_count`=4.
- `reset` asserted after the 5th byte of a load → state RUN, all `mem`=8'h00, `load_count`=0; `load_start` during the reset cycle is ignored.
- `load_start` pulsed while in LOAD and in FILL → no restart; `wr_ptr` and the sequence are unaffected.
